display_scan: RTL and testbench
===============================

DISPLAY_SCAN -- requirements
Module: display_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, meaning clock cycles per digit slot (legal range 4..65535).
REQ-002 SHALL have parameter DEAD, default 2, meaning anode-off cycles at the start of each slot (legal range 1..SCAN_DIV-2).
REQ-003 SHALL have parameter BLINK_HALF, default 64, meaning frames per blink half-period (legal range 1..255).
REQ-004 SHALL have port clk, input, width 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, width 1: asynchronous, active-low reset.
REQ-006 SHALL have port digits_in, input, width 32: eight 4-bit codes; digit i occupies [4i+3:4i]; digit 0 is rightmost.
REQ-007 SHALL have port load, input, width 1: single-cycle request to capture digits_in.
REQ-008 SHALL have port blink_mask, input, width 8: bit i set means digit i blinks.
REQ-009 SHALL have port lz_blank_en, input, width 1: enables leading-zero blanking.
REQ-010 SHALL have port digit_out, output, width 4: code for the active slot, feeding the 7-segment decoder; 4'hF means blank.
REQ-011 SHALL have port anode_n, output, width 8: active-low one-hot digit enable.
REQ-012 SHALL have port frame_tick, output, width 1: one-cycle pulse in the first cycle of slot 0.

Function
REQ-013 SHALL keep a prescaler cnt (0..SCAN_DIV-1) and a slot index idx (0..7); cnt increments every cycle.
REQ-014 SHALL, at cnt==SCAN_DIV-1, set cnt to 0 and advance idx by 1, with idx 7 wrapping to 0 (frame boundary).
REQ-015 SHALL hold a pending register plus pending_valid flag and a display register; load sets pending=digits_in and pending_valid=1.
REQ-016 SHALL, at a frame boundary with pending_valid=1, copy pending to display and clear pending_valid; display never changes mid-frame.
REQ-017 SHALL, when load coincides with a frame boundary, copy digits_in directly to display and leave pending_valid=0.
REQ-018 SHALL, on back-to-back loads within one frame, let the last load win.
REQ-019 SHALL mark digit i as LZ-blanked when lz_blank_en=1, i>0, and display digits i..7 all equal 4'h0; digit 0 is never LZ-blanked, and 4'hA (dash) is non-zero.
REQ-020 SHALL keep a frame counter and blink_phase bit, toggling blink_phase after every BLINK_HALF completed frames; both are cleared by reset only.
REQ-021 SHALL drive digit_out=4'hF for slot idx if it is LZ-blanked, or if blink_phase=1 and blink_mask[idx]=1; otherwise digit_out=display digit idx.
REQ-022 SHALL pass codes 4'hB..4'hE through unchanged, with no sanitising.
REQ-023 SHALL drive anode_n=8'hFF while cnt<DEAD, else anode_n=~(8'b1<<idx); anode_n stays enabled even for blanked digits.
REQ-024 SHALL register all outputs so that digit_out, anode_n, and frame_tick reflect the cnt/idx of the same cycle, with no combinational path from inputs.
REQ-025 SHALL assert frame_tick for exactly one cycle, when idx==0 and cnt==0, including the first cycle after reset release.
REQ-026 SHALL sample blink_mask and lz_blank_en every cycle and apply them without frame alignment.

Reset
REQ-027 SHALL, while rst_n=0, immediately force cnt=0, idx=0, pending=display=32'hFFFFFFFF, pending_valid=0, frame counter=0, blink_phase=0, digit_out=4'hF, anode_n=8'hFF, and frame_tick=0.
REQ-028 SHALL, on rst_n assertion mid-frame or mid-pending, abort everything and not apply the pending data.
REQ-029 SHALL begin slot 0 with cnt=0 in the first clock after rst_n rises, asserting frame_tick in that cycle.

Verification
REQ-030 SHALL cover, with SCAN_DIV=4, DEAD=1, no load after reset: anode_n sequence FF,FE,FE,FE,FF,FD,...; digit_out=F throughout; frame_tick every 32 cycles.
REQ-031 SHALL cover a load of 32'h12345678 issued mid-slot 3: digit_out unchanged until the next frame_tick, then slots 0..7 show 8,7,6,5,4,3,2,1.
REQ-032 SHALL cover lz_blank_en=1 with display 32'h00000A05: slots 0,1,2 show 5,0,A and slots 3..7 show F; with display 32'h00000000, slot 0 shows 0 and slots 1..7 show F.
REQ-033 SHALL cover BLINK_HALF=2, blink_mask=8'h03, display 32'h00000099: slots 0-1 show 9 for frames 0-1, F for frames 2-3, and 9 again for frames 4-5; other slots are unaffected.
REQ-034 SHALL cover load asserted exactly at a frame boundary with 32'hAAAAAAAA: the new frame shows A in every slot and pending_valid=0.
REQ-035 SHALL cover rst_n pulled low mid-slot 5 with a pending load outstanding: outputs go to F/FF/0 asynchronously, and after release the display stays blank (F).

Source files
------------

// File: rtl/display_scan.sv
// display_scan: eight-digit multiplexed 7-segment scanner.
// Each digit slot lasts SCAN_DIV cycles and begins with DEAD cycles with all
// anodes off. New digit data is double-buffered and shown only from a frame
// start. Leading zeros can be blanked, and selected digits blink.
// Outputs are registered from the next-state values, so every output matches
// the slot and prescaler position of the cycle in which it is visible.
module display_scan #(
    parameter int SCAN_DIV   = 50000,
    parameter int DEAD       = 2,
    parameter int BLINK_HALF = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] digits_in,
    input  logic        load,
    input  logic [7:0]  blink_mask,
    input  logic        lz_blank_en,
    output logic [3:0]  digit_out,
    output logic [7:0]  anode_n,
    output logic        frame_tick
);

    localparam logic [15:0] CNT_MAX   = 16'(SCAN_DIV - 1);
    localparam logic [15:0] DEAD_C    = 16'(DEAD);
    localparam logic [7:0]  BLINK_MAX = 8'(BLINK_HALF - 1);

    logic [15:0] cnt, cnt_nxt;
    logic [2:0]  idx, idx_nxt;
    logic        run;
    logic [31:0] pending, pending_nxt;
    logic        pending_valid, pending_valid_nxt;
    logic [31:0] display, display_nxt;
    logic [7:0]  fcnt, fcnt_nxt;
    logic        blink_phase, blink_phase_nxt;
    logic        wrap;
    logic        boundary;
    logic        lz_blank;
    logic [3:0]  digit_nxt;
    logic [7:0]  anode_nxt;
    logic        tick_nxt;

    // Next-state for scan position, buffers, blink timing and output values.
    always_comb begin
        cnt_nxt           = cnt + 16'd1;
        idx_nxt           = idx;
        pending_nxt       = pending;
        pending_valid_nxt = pending_valid;
        display_nxt       = display;
        fcnt_nxt          = fcnt;
        blink_phase_nxt   = blink_phase;
        lz_blank          = 1'b0;
        digit_nxt         = 4'hF;
        anode_nxt         = 8'hFF;
        tick_nxt          = 1'b0;

        // The first edge after reset release opens frame 0 at cnt=0.
        wrap     = run && (cnt == CNT_MAX) && (idx == 3'd7);
        boundary = !run || wrap;

        if (!run) begin
            cnt_nxt = 16'd0;
            idx_nxt = 3'd0;
        end else if (cnt == CNT_MAX) begin
            cnt_nxt = 16'd0;
            idx_nxt = idx + 3'd1;
        end

        // Only genuinely completed frames advance the blink timer.
        if (wrap) begin
            if (fcnt == BLINK_MAX) begin
                fcnt_nxt        = 8'd0;
                blink_phase_nxt = !blink_phase;
            end else begin
                fcnt_nxt = fcnt + 8'd1;
            end
        end

        // A load landing on a frame start bypasses the pending buffer.
        if (load) begin
            pending_nxt = digits_in;
            if (boundary) begin
                display_nxt       = digits_in;
                pending_valid_nxt = 1'b0;
            end else begin
                pending_valid_nxt = 1'b1;
            end
        end else if (boundary && pending_valid) begin
            display_nxt       = pending;
            pending_valid_nxt = 1'b0;
        end

        lz_blank  = lz_blank_en && (idx_nxt != 3'd0) &&
                    ((display_nxt >> {idx_nxt, 2'b00}) == 32'd0);
        digit_nxt = display_nxt[{idx_nxt, 2'b00} +: 4];
        if (lz_blank || (blink_phase_nxt && blink_mask[idx_nxt]))
            digit_nxt = 4'hF;

        if (cnt_nxt >= DEAD_C)
            anode_nxt = ~(8'b1 << idx_nxt);
        tick_nxt = (cnt_nxt == 16'd0) && (idx_nxt == 3'd0);
    end

    // Scan, buffer and blink state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= 16'd0;
            idx           <= 3'd0;
            run           <= 1'b0;
            pending       <= 32'hFFFF_FFFF;
            pending_valid <= 1'b0;
            display       <= 32'hFFFF_FFFF;
            fcnt          <= 8'd0;
            blink_phase   <= 1'b0;
        end else begin
            cnt           <= cnt_nxt;
            idx           <= idx_nxt;
            run           <= 1'b1;
            pending       <= pending_nxt;
            pending_valid <= pending_valid_nxt;
            display       <= display_nxt;
            fcnt          <= fcnt_nxt;
            blink_phase   <= blink_phase_nxt;
        end
    end

    // Registered outputs, aligned with the cnt/idx of the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_out  <= 4'hF;
            anode_n    <= 8'hFF;
            frame_tick <= 1'b0;
        end else begin
            digit_out  <= digit_nxt;
            anode_n    <= anode_nxt;
            frame_tick <= tick_nxt;
        end
    end

endmodule

// File: tb/tb_display_scan.sv
// Testbench for display_scan with a short scan period. The reference model
// works from the absolute cycle number since reset release: slot, prescaler
// position and frame number are plain divisions of it.
module tb_display_scan;

    localparam int SCAN_DIV   = 4;
    localparam int DEAD       = 1;
    localparam int BLINK_HALF = 2;
    localparam int FRAME      = SCAN_DIV * 8;

    logic        clk;
    logic        rst_n;
    logic [31:0] digits_in;
    logic        load;
    logic [7:0]  blink_mask;
    logic        lz_blank_en;
    logic [3:0]  digit_out;
    logic [7:0]  anode_n;
    logic        frame_tick;

    int n_tests;
    int n_failed;

    // Model state: k is the cycle index of the outputs currently visible.
    int          k;
    logic [31:0] m_disp;
    logic [31:0] m_pend;
    logic        m_pv;
    logic [3:0]  e_digit;
    logic [7:0]  e_anode;
    logic        e_tick;

    display_scan #(
        .SCAN_DIV  (SCAN_DIV),
        .DEAD      (DEAD),
        .BLINK_HALF(BLINK_HALF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .digits_in  (digits_in),
        .load       (load),
        .blink_mask (blink_mask),
        .lz_blank_en(lz_blank_en),
        .digit_out  (digit_out),
        .anode_n    (anode_n),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_failed++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, k, got, exp);
        end
    endtask

    task automatic model_reset();
        k      = -1;
        m_disp = 32'hFFFF_FFFF;
        m_pend = 32'hFFFF_FFFF;
        m_pv   = 1'b0;
    endtask

    // Behaviour at the edge that produces output cycle k.
    task automatic model_edge();
        int  slot;
        int  frame;
        bit  phase;
        bit  lz;
        if (k % FRAME == 0) begin
            if (load) begin
                m_disp = digits_in;
                m_pv   = 1'b0;
            end else if (m_pv) begin
                m_disp = m_pend;
                m_pv   = 1'b0;
            end
        end else if (load) begin
            m_pend = digits_in;
            m_pv   = 1'b1;
        end
        slot  = (k / SCAN_DIV) % 8;
        frame = k / FRAME;
        phase = ((frame / BLINK_HALF) % 2) == 1;
        lz    = lz_blank_en && slot > 0 && ((m_disp >> (4 * slot)) == 32'd0);
        e_digit = 4'((m_disp >> (4 * slot)) & 32'hF);
        if (lz || (phase && blink_mask[slot]))
            e_digit = 4'hF;
        e_anode = ((k % SCAN_DIV) < DEAD) ? 8'hFF : ~(8'h01 << slot);
        e_tick  = (k % FRAME) == 0;
    endtask

    task automatic tick_cycle();
        @(posedge clk);
        k++;
        model_edge();
        @(negedge clk);
        check("digit_out", 32'(digit_out), 32'(e_digit));
        check("anode_n", 32'(anode_n), 32'(e_anode));
        check("frame_tick", 32'(frame_tick), 32'(e_tick));
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) tick_cycle();
    endtask

    // Advance until the visible cycle sits at a given position in the frame.
    task automatic wait_pos(input int pos);
        int guard;
        guard = 0;
        while ((k % FRAME) != pos && guard < 4 * FRAME) begin
            tick_cycle();
            guard++;
        end
        if (guard >= 4 * FRAME) check("wait_pos_timeout", 32'(guard), 32'(0));
    endtask

    task automatic do_load(input logic [31:0] val);
        digits_in = val;
        load      = 1'b1;
        tick_cycle();
        load      = 1'b0;
        digits_in = 32'(($urandom));
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_digit"}, 32'(digit_out), 32'hF);
        check({tag, "_anode"}, 32'(anode_n), 32'hFF);
        check({tag, "_tick"}, 32'(frame_tick), 32'h0);
    endtask

    logic [31:0] pat [6];

    initial begin
        n_tests     = 0;
        n_failed    = 0;
        rst_n       = 1'b1;
        load        = 1'b0;
        digits_in   = 32'h0;
        blink_mask  = 8'h00;
        lz_blank_en = 1'b0;
        pat[0] = 32'h1234_5678;
        pat[1] = 32'h0000_0A05;
        pat[2] = 32'h0000_0000;
        pat[3] = 32'h0000_0099;
        pat[4] = 32'hAAAA_AAAA;
        pat[5] = 32'hEDCB_0B0E;
        model_reset();

        // Asynchronous reset at start, before any clock edge.
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst_async");
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("rst_held");
        release_reset();

        // Free-running scan with no data: blank digits, dead-time pattern.
        run_cycles(2 * FRAME + 8);

        // Load in the middle of slot 3, takes effect at the next frame.
        wait_pos(12);
        do_load(pat[0]);
        run_cycles(2 * FRAME);

        // Leading-zero blanking with a dash, then an all-zero display.
        lz_blank_en = 1'b1;
        wait_pos(5);
        do_load(pat[1]);
        run_cycles(FRAME + 4);
        wait_pos(9);
        do_load(pat[2]);
        run_cycles(FRAME + 4);

        // Back-to-back loads in one frame: last one wins.
        lz_blank_en = 1'b0;
        wait_pos(3);
        do_load(pat[5]);
        do_load(pat[0]);
        run_cycles(FRAME);

        // Blink on the two low digits across several frames.
        blink_mask = 8'h03;
        wait_pos(7);
        do_load(pat[3]);
        run_cycles(6 * FRAME);
        blink_mask = 8'h00;

        // Load exactly at a frame boundary: applied immediately.
        wait_pos(FRAME - 1);
        do_load(pat[4]);
        run_cycles(2 * FRAME);

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) < 6) begin
                digits_in = ($urandom_range(0, 1) == 0) ? pat[$urandom_range(0, 5)] : 32'($urandom);
                load      = 1'b1;
            end else begin
                load = 1'b0;
            end
            if ($urandom_range(0, 99) < 8) blink_mask = 8'($urandom);
            if ($urandom_range(0, 99) < 8) lz_blank_en = 1'($urandom);
            tick_cycle();
        end
        load        = 1'b0;
        blink_mask  = 8'h00;
        lz_blank_en = 1'b0;

        // Reset mid-slot 5 with a pending load outstanding.
        wait_pos(8);
        do_load(pat[0]);
        wait_pos(21);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst_mid");
        @(negedge clk);
        check_reset_outputs("rst_mid_held");
        release_reset();
        run_cycles(2 * FRAME);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
